dap_cmd_dispatcher: RTL and testbench

Sequences the DAP command handlers (SWJ/SWD transfer, transfer-block, info, etc.) that share one inbound command byte stream and one response RAM. It peeks the command ID byte without consuming it, maps the ID to a handler index, and asserts that handler's start bit. It then routes the input-stream ready from the selected handler only and waits for that handler's done. IDs with no handler are consumed by the dispatcher itself, which writes a one-byte 0xFF error response.

---
 rtl/dap_cmd_dispatcher_pkg.sv | 54 +++++
 rtl/dap_cmd_dispatcher_watchdog.sv | 40 ++++
 rtl/dap_cmd_dispatcher.sv | 178 +++++++++++++++++
 tb/tb_dap_cmd_dispatcher.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dap_cmd_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// dap_cmd_pkg
// Shared definitions for the DAP command dispatcher:
//   - DAP command ID byte values handled in hardware
//   - handler slot index for each ID (bit position in start/done/handler_tready)
//   - cmd_to_idx(): maps an ID byte to {valid, idx[2:0]}
//   - dispatcher FSM state encoding
// -----------------------------------------------------------------------------
package dap_cmd_pkg;

    localparam logic [7:0] ID_INFO               = 8'h00;
    localparam logic [7:0] ID_HOST_STATUS        = 8'h01;
    localparam logic [7:0] ID_CONNECT            = 8'h02;
    localparam logic [7:0] ID_DISCONNECT         = 8'h03;
    localparam logic [7:0] ID_TRANSFER_CONFIGURE = 8'h04;
    localparam logic [7:0] ID_TRANSFER           = 8'h05;
    localparam logic [7:0] ID_TRANSFER_BLOCK     = 8'h06;
    localparam logic [7:0] ID_SWJ_SEQUENCE       = 8'h12;

    localparam logic [2:0] IDX_INFO               = 3'd0;
    localparam logic [2:0] IDX_HOST_STATUS        = 3'd1;
    localparam logic [2:0] IDX_CONNECT            = 3'd2;
    localparam logic [2:0] IDX_DISCONNECT         = 3'd3;
    localparam logic [2:0] IDX_TRANSFER_CONFIGURE = 3'd4;
    localparam logic [2:0] IDX_TRANSFER           = 3'd5;
    localparam logic [2:0] IDX_TRANSFER_BLOCK     = 3'd6;
    localparam logic [2:0] IDX_SWJ_SEQUENCE       = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_RUN     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    // Returns {valid, idx}; valid=0 for IDs without a hardware handler.
    function automatic logic [3:0] cmd_to_idx(input logic [7:0] id);
        logic [3:0] r;
        case (id)
            ID_INFO:               r = {1'b1, IDX_INFO};
            ID_HOST_STATUS:        r = {1'b1, IDX_HOST_STATUS};
            ID_CONNECT:            r = {1'b1, IDX_CONNECT};
            ID_DISCONNECT:         r = {1'b1, IDX_DISCONNECT};
            ID_TRANSFER_CONFIGURE: r = {1'b1, IDX_TRANSFER_CONFIGURE};
            ID_TRANSFER:           r = {1'b1, IDX_TRANSFER};
            ID_TRANSFER_BLOCK:     r = {1'b1, IDX_TRANSFER_BLOCK};
            ID_SWJ_SEQUENCE:       r = {1'b1, IDX_SWJ_SEQUENCE};
            default:               r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dap_cmd_dispatcher_watchdog.sv
// -----------------------------------------------------------------------------
// dap_dispatch_watchdog
// Counts clk cycles a handler spends running and flags expiry.
// Only compiled when DAP_DISPATCH_TIMEOUT_EN is defined; otherwise this file
// contributes no module at all.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   clear      : zero the counter (asserted on the edge entering RUN)
//   run        : dispatcher is in RUN; counter advances each such cycle
//   expire     : high while running and the count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
`ifdef DAP_DISPATCH_TIMEOUT_EN
module dap_dispatch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] r_count;

    assign expire = run && (r_count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run && !expire) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/dap_cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// dap_cmd_dispatcher
// Peeks the DAP command ID byte, starts the matching handler, routes stream
// ready from that handler only, and waits for its done handshake. Unknown IDs
// are consumed here and answered with a single 0xFF response byte.
// Optional feature macro: DAP_DISPATCH_TIMEOUT_EN (RUN watchdog).
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   dap_in_tvalid/tdata/tready : inbound command byte stream
//   handler_tready    : per-handler stream ready
//   start / done      : one-hot handler start (level) / per-handler done
//   cmd_id, busy      : latched command ID, packet in progress
//   err_write_*       : response RAM write of the 0xFF error byte
//   err_packet_len    : 1 after an error response until the next packet
//   pkt_done, pkt_err : end-of-packet pulse and its error qualifier
// -----------------------------------------------------------------------------
module dap_cmd_dispatcher
    import dap_cmd_pkg::*;
#(
    parameter int unsigned CMD_NUM        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dap_in_tvalid,
    input  logic [7:0]         dap_in_tdata,
    output logic               dap_in_tready,
    input  logic [CMD_NUM-1:0] handler_tready,
    output logic [CMD_NUM-1:0] start,
    input  logic [CMD_NUM-1:0] done,
    output logic [7:0]         cmd_id,
    output logic               busy,
    output logic               err_write_en,
    output logic [9:0]         err_write_addr,
    output logic [7:0]         err_write_data,
    output logic [9:0]         err_packet_len,
    output logic               pkt_done,
    output logic               pkt_err
);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_cmd_id;
    logic               r_busy;
    logic [CMD_NUM-1:0] r_start;
    logic               r_err_len;

    logic [3:0]         w_map;
    logic [2:0]         w_idx;
    logic               w_valid;
    logic               w_sel_done;
    logic               w_expire;
    logic               w_tmo;

    // cmd_id is stable for the whole packet, so the index is decoded
    // combinationally from it rather than stored separately.
    assign w_map      = cmd_to_idx(r_cmd_id);
    assign w_idx      = w_map[2:0];
    assign w_valid    = w_map[3] && (32'(w_idx) < CMD_NUM);
    assign w_sel_done = done[w_idx];

`ifdef DAP_DISPATCH_TIMEOUT_EN
    logic r_tmo;

    dap_dispatch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (r_state == ST_DECODE && w_next == ST_RUN),
        .run   (r_state == ST_RUN),
        .expire(w_expire)
    );

    // Marks that the current ERR came from a timeout: the handler may still
    // hold done, so the packet exits via RELEASE instead of straight to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo <= 1'b0;
        end else if (r_state == ST_IDLE && dap_in_tvalid) begin
            r_tmo <= 1'b0;
        end else if (r_state == ST_RUN && w_next == ST_ERR) begin
            r_tmo <= 1'b1;
        end
    end

    assign w_tmo = r_tmo;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_expire     = 1'b0;
    assign w_tmo        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; done has priority over watchdog expiry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (dap_in_tvalid) w_next = ST_DECODE;
            ST_DECODE:  w_next = w_valid ? ST_RUN : ST_ERR;
            ST_RUN: begin
                if (w_sel_done) begin
                    w_next = ST_RELEASE;
                end else if (w_expire) begin
                    w_next = ST_ERR;
                end
            end
            ST_RELEASE: if (!w_sel_done) w_next = ST_IDLE;
            ST_ERR:     w_next = w_tmo ? ST_RELEASE : ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        dap_in_tready = 1'b0;
        err_write_en  = 1'b0;
        pkt_done      = 1'b0;
        pkt_err       = 1'b0;
        case (r_state)
            ST_DECODE:  dap_in_tready = !w_valid;
            ST_RUN:     dap_in_tready = handler_tready[w_idx];
            // After a timeout the packet was already reported from ERR.
            ST_RELEASE: pkt_done = !w_sel_done && !w_tmo;
            ST_ERR: begin
                err_write_en = 1'b1;
                pkt_done     = 1'b1;
                pkt_err      = 1'b1;
            end
            default: ;
        endcase
    end

    // Packet-level registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_id  <= '0;
            r_busy    <= 1'b0;
            r_start   <= '0;
            r_err_len <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && dap_in_tvalid) begin
                r_cmd_id  <= dap_in_tdata;
                r_busy    <= 1'b1;
                r_err_len <= 1'b0;
            end
            if (r_state == ST_DECODE && w_valid) begin
                r_start <= CMD_NUM'(1) << w_idx;
            end
            if (r_state == ST_RUN && w_next != ST_RUN) begin
                r_start <= '0;
            end
            if (w_next == ST_ERR && r_state != ST_ERR) begin
                r_err_len <= 1'b1;
            end
            if (w_next == ST_IDLE && r_state != ST_IDLE) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign start          = r_start;
    assign cmd_id         = r_cmd_id;
    assign busy           = r_busy;
    assign err_write_addr = '0;
    assign err_write_data = '1;
    assign err_packet_len = {9'b0, r_err_len};

endmodule

// File: tb/tb_dap_cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_dap_cmd_dispatcher
// Directed, table-driven bench for dap_cmd_dispatcher plus hand-written
// multi-cycle sequences (foreign done, reset in RUN, back-to-back, watchdog).
// -----------------------------------------------------------------------------
module tb_dap_cmd_dispatcher;

    localparam int unsigned CMD_NUM = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               dap_in_tvalid;
    logic [7:0]         dap_in_tdata;
    logic               dap_in_tready;
    logic [CMD_NUM-1:0] handler_tready;
    logic [CMD_NUM-1:0] start;
    logic [CMD_NUM-1:0] done;
    logic [7:0]         cmd_id;
    logic               busy;
    logic               err_write_en;
    logic [9:0]         err_write_addr;
    logic [7:0]         err_write_data;
    logic [9:0]         err_packet_len;
    logic               pkt_done;
    logic               pkt_err;

    always #5 clk = ~clk;

    dap_cmd_dispatcher #(
        .CMD_NUM(CMD_NUM),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dap_in_tvalid(dap_in_tvalid),
        .dap_in_tdata(dap_in_tdata),
        .dap_in_tready(dap_in_tready),
        .handler_tready(handler_tready),
        .start(start),
        .done(done),
        .cmd_id(cmd_id),
        .busy(busy),
        .err_write_en(err_write_en),
        .err_write_addr(err_write_addr),
        .err_write_data(err_write_data),
        .err_packet_len(err_packet_len),
        .pkt_done(pkt_done),
        .pkt_err(pkt_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] id;
        logic       exp_err;
        logic [7:0] exp_start;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // At most one start bit may ever be high.
    always @(negedge clk) begin
        n_total++;
        if ($onehot0(start)) n_pass++;
        else $display("FAIL start_onehot: got %b required at most one bit set", start);
    end

    // Full packet from IDLE back to IDLE for one table entry.
    task automatic run_packet(input vec_t v);
        dap_in_tvalid  = 1'b1;
        dap_in_tdata   = v.id;
        handler_tready = '0;
        done           = '0;
        #1;
        chk("idle_tready", dap_in_tready, 0);
        chk("idle_busy", busy, 0);
        cyc();
        chk("dec_cmd_id", cmd_id, v.id);
        chk("dec_busy", busy, 1);
        chk("dec_start", start, 0);
        chk("dec_tready", dap_in_tready, v.exp_err);
        if (v.exp_err) dap_in_tvalid = 1'b0;
        cyc();
        if (v.exp_err) begin
            chk("err_we", err_write_en, 1);
            chk("err_addr", err_write_addr, 0);
            chk("err_data", err_write_data, 8'hFF);
            chk("err_len", err_packet_len, 1);
            chk("err_pkt_done", pkt_done, 1);
            chk("err_pkt_err", pkt_err, 1);
            chk("err_tready", dap_in_tready, 0);
            chk("err_start", start, 0);
            cyc();
            chk("err_after_busy", busy, 0);
            chk("err_after_pkt_done", pkt_done, 0);
            chk("err_after_we", err_write_en, 0);
            chk("err_len_hold", err_packet_len, 1);
        end else begin
            chk("run_start", start, v.exp_start);
            chk("run_pkt_done", pkt_done, 0);
            chk("run_err_len", err_packet_len, 0);
            handler_tready = ~v.exp_start;
            #1 chk("run_tready_other", dap_in_tready, 0);
            handler_tready = v.exp_start;
            #1 chk("run_tready_sel", dap_in_tready, 1);
            dap_in_tvalid = 1'b0;
            done = v.exp_start;
            #1 chk("run_start_done", start, v.exp_start);
            cyc();
            chk("rel_start", start, 0);
            chk("rel_busy", busy, 1);
            chk("rel_pkt_done_wait", pkt_done, 0);
            chk("rel_tready", dap_in_tready, 0);
            done = '0;
            handler_tready = '0;
            #1;
            chk("rel_pkt_done", pkt_done, 1);
            chk("rel_pkt_err", pkt_err, 0);
            cyc();
            chk("end_busy", busy, 0);
            chk("end_pkt_done", pkt_done, 0);
        end
    endtask

    // Present id and advance to the first RUN cycle.
    task automatic to_run(input logic [7:0] id);
        dap_in_tvalid = 1'b1;
        dap_in_tdata  = id;
        cyc();
        cyc();
        dap_in_tvalid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{8'h05, 1'b0, 8'h20};
        vecs[1]  = '{8'h7E, 1'b1, 8'h00};
        vecs[2]  = '{8'h06, 1'b0, 8'h40};
        vecs[3]  = '{8'h00, 1'b0, 8'h01};
        vecs[4]  = '{8'h01, 1'b0, 8'h02};
        vecs[5]  = '{8'h02, 1'b0, 8'h04};
        vecs[6]  = '{8'h03, 1'b0, 8'h08};
        vecs[7]  = '{8'h04, 1'b0, 8'h10};
        vecs[8]  = '{8'h12, 1'b0, 8'h80};
        vecs[9]  = '{8'h07, 1'b1, 8'h00};
        vecs[10] = '{8'h11, 1'b1, 8'h00};
        vecs[11] = '{8'hFF, 1'b1, 8'h00};
        vecs[12] = '{8'h13, 1'b1, 8'h00};
        vecs[13] = '{8'h05, 1'b0, 8'h20};

        // Reset wins over active inputs.
        dap_in_tvalid  = 1'b1;
        dap_in_tdata   = 8'h05;
        handler_tready = '1;
        done           = '1;
        cyc();
        cyc();
        chk("rst_start", start, 0);
        chk("rst_tready", dap_in_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_id", cmd_id, 0);
        chk("rst_err_we", err_write_en, 0);
        chk("rst_err_len", err_packet_len, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_pkt_err", pkt_err, 0);
        reset          = 1'b0;
        dap_in_tvalid  = 1'b0;
        handler_tready = '0;
        done           = '0;
        cyc();

        for (int i = 0; i < 14; i++) run_packet(vecs[i]);

        // done of an unselected handler is ignored.
        to_run(8'h05);
        done = 8'h40;
        cyc();
        chk("foreign_done_start", start, 8'h20);
        chk("foreign_done_pkt", pkt_done, 0);
        cyc();
        chk("foreign_done_start2", start, 8'h20);
        done = 8'h20;
        cyc();
        chk("foreign_rel_start", start, 0);
        done = '0;
        #1 chk("foreign_pkt_done", pkt_done, 1);
        cyc();

        // Reset while RUN, then replay the packet.
        handler_tready = 8'h20;
        to_run(8'h05);
        chk("rstrun_start_pre", start, 8'h20);
        dap_in_tvalid = 1'b1;
        reset = 1'b1;
        cyc();
        chk("rstrun_start", start, 0);
        chk("rstrun_busy", busy, 0);
        chk("rstrun_cmd_id", cmd_id, 0);
        chk("rstrun_tready", dap_in_tready, 0);
        reset = 1'b0;
        dap_in_tvalid = 1'b0;
        cyc();
        chk("rstrun_idle_busy", busy, 0);
        run_packet(vecs[0]);

        // Back-to-back 0x00 then 0x12 with tvalid held.
        dap_in_tvalid = 1'b1;
        dap_in_tdata  = 8'h00;
        cyc();
        cyc();
        chk("b2b_start0", start, 8'h01);
        done = 8'h01;
        cyc();
        done = '0;
        dap_in_tdata = 8'h12;
        #1 chk("b2b_pkt_done0", pkt_done, 1);
        cyc();
        chk("b2b_gap_busy", busy, 0);
        chk("b2b_gap_cmd_id", cmd_id, 8'h00);
        chk("b2b_gap_start", start, 0);
        cyc();
        chk("b2b_dec_cmd_id", cmd_id, 8'h12);
        chk("b2b_dec_start", start, 0);
        cyc();
        chk("b2b_start7", start, 8'h80);
        dap_in_tvalid = 1'b0;
        done = 8'h80;
        cyc();
        done = '0;
        #1 chk("b2b_pkt_done1", pkt_done, 1);
        cyc();

`ifdef DAP_DISPATCH_TIMEOUT_EN
        // Handler never finishes: expiry after 16 RUN cycles.
        to_run(8'h05);
        for (int k = 1; k < 16; k++) cyc();
        chk("tmo_start_last", start, 8'h20);
        chk("tmo_no_err_yet", err_write_en, 0);
        cyc();
        chk("tmo_start", start, 0);
        chk("tmo_we", err_write_en, 1);
        chk("tmo_data", err_write_data, 8'hFF);
        chk("tmo_pkt_done", pkt_done, 1);
        chk("tmo_pkt_err", pkt_err, 1);
        chk("tmo_len", err_packet_len, 1);
        cyc();
        chk("tmo_rel_pkt_done", pkt_done, 0);
        chk("tmo_rel_busy", busy, 1);
        cyc();
        chk("tmo_end_busy", busy, 0);

        // done in the expiry cycle wins.
        to_run(8'h05);
        for (int k = 1; k < 16; k++) cyc();
        done = 8'h20;
        cyc();
        chk("tmo_race_we", err_write_en, 0);
        chk("tmo_race_start", start, 0);
        done = '0;
        #1;
        chk("tmo_race_pkt_done", pkt_done, 1);
        chk("tmo_race_pkt_err", pkt_err, 0);
        cyc();
`else
        // Without the watchdog RUN waits indefinitely.
        to_run(8'h05);
        for (int k = 0; k < 40; k++) cyc();
        chk("notmo_start", start, 8'h20);
        chk("notmo_we", err_write_en, 0);
        chk("notmo_busy", busy, 1);
        done = 8'h20;
        cyc();
        done = '0;
        #1 chk("notmo_pkt_done", pkt_done, 1);
        cyc();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
